ysyx_24100006_xbar: RTL and testbench

AXI-Lite 1-to-3 crossbar between the core's LSU master port and the memory-mapped slaves: main memory (slot 0), the UART (slot 1) and the CLINT (slot 2). It decodes each request address, forwards exactly one transaction at a time to the selected slave, and routes the response back to the master. Addresses that hit no slot are answered internally with a DECERR response, so the master never hangs.

---
 rtl/ysyx_24100006_xbar.sv | 231 +++++++++++++++++++++++
 tb/tb_ysyx_24100006_xbar.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_xbar.sv
// AXI-Lite 1-to-3 crossbar: LSU master to memory (slot 0), UART (slot 1), CLINT (slot 2).
// One transaction at a time; unmapped addresses are answered locally with DECERR.
module ysyx_24100006_xbar #(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
  parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0008,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  // master side
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  input  logic [31:0] m_awaddr,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_wready,
  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,
  // slot 0
  output logic [31:0] s0_araddr,
  output logic        s0_arvalid,
  input  logic        s0_arready,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  output logic [31:0] s0_awaddr,
  output logic        s0_awvalid,
  input  logic        s0_awready,
  output logic [31:0] s0_wdata,
  output logic [3:0]  s0_wstrb,
  output logic        s0_wvalid,
  input  logic        s0_wready,
  input  logic [1:0]  s0_bresp,
  input  logic        s0_bvalid,
  output logic        s0_bready,
  // slot 1
  output logic [31:0] s1_araddr,
  output logic        s1_arvalid,
  input  logic        s1_arready,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp,
  input  logic        s1_rvalid,
  output logic        s1_rready,
  output logic [31:0] s1_awaddr,
  output logic        s1_awvalid,
  input  logic        s1_awready,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wvalid,
  input  logic        s1_wready,
  input  logic [1:0]  s1_bresp,
  input  logic        s1_bvalid,
  output logic        s1_bready,
  // slot 2
  output logic [31:0] s2_araddr,
  output logic        s2_arvalid,
  input  logic        s2_arready,
  input  logic [31:0] s2_rdata,
  input  logic [1:0]  s2_rresp,
  input  logic        s2_rvalid,
  output logic        s2_rready,
  output logic [31:0] s2_awaddr,
  output logic        s2_awvalid,
  input  logic        s2_awready,
  output logic [31:0] s2_wdata,
  output logic [3:0]  s2_wstrb,
  output logic        s2_wvalid,
  input  logic        s2_wready,
  input  logic [1:0]  s2_bresp,
  input  logic        s2_bvalid,
  output logic        s2_bready
);

  typedef enum logic [2:0] {
    StIdle, StRd, StWr, StRdErrA, StRdErrR, StWrErrA, StWrErrB
  } state_e;

  localparam logic [1:0] SelMiss = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;

  // 33-bit compare so a window ending exactly at 2^32 does not wrap.
  function automatic logic [1:0] decode(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr};
    if (a >= {1'b0, MEM_BASE} && a < {1'b0, MEM_BASE} + {1'b0, MEM_SIZE}) return 2'd0;
    if (a >= {1'b0, UART_BASE} && a < {1'b0, UART_BASE} + {1'b0, UART_SIZE}) return 2'd1;
    if (a >= {1'b0, CLINT_BASE} && a < {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE}) return 2'd2;
    return SelMiss;
  endfunction

  logic [2:0]  sel_oh;
  logic [2:0]  s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
  logic [2:0]  s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
  logic [31:0] sel_rdata;
  logic [1:0]  sel_rresp, sel_bresp;
  logic [1:0]  ar_sel, aw_sel;

  assign sel_oh    = {sel_q == 2'd2, sel_q == 2'd1, sel_q == 2'd0};
  assign s_arready = {s2_arready, s1_arready, s0_arready};
  assign s_awready = {s2_awready, s1_awready, s0_awready};
  assign s_wready  = {s2_wready, s1_wready, s0_wready};
  assign s_rvalid  = {s2_rvalid, s1_rvalid, s0_rvalid};
  assign s_bvalid  = {s2_bvalid, s1_bvalid, s0_bvalid};
  assign ar_sel    = decode(m_araddr);
  assign aw_sel    = decode(m_awaddr);

  always_comb begin
    sel_rdata = 32'h0;
    sel_rresp = 2'b00;
    sel_bresp = 2'b00;
    case (sel_q)
      2'd0: begin sel_rdata = s0_rdata; sel_rresp = s0_rresp; sel_bresp = s0_bresp; end
      2'd1: begin sel_rdata = s1_rdata; sel_rresp = s1_rresp; sel_bresp = s1_bresp; end
      2'd2: begin sel_rdata = s2_rdata; sel_rresp = s2_rresp; sel_bresp = s2_bresp; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'h0;
    m_rresp   = 2'b00;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    s_arvalid = 3'b000;
    s_rready  = 3'b000;
    s_awvalid = 3'b000;
    s_wvalid  = 3'b000;
    s_bready  = 3'b000;
    case (state_q)
      StIdle: begin
        if (m_arvalid) begin
          sel_d   = ar_sel;
          state_d = (ar_sel == SelMiss) ? StRdErrA : StRd;
        end else if (m_awvalid && m_wvalid) begin
          sel_d   = aw_sel;
          state_d = (aw_sel == SelMiss) ? StWrErrA : StWr;
        end
      end
      StRd: begin
        s_arvalid = sel_oh & {3{m_arvalid}};
        s_rready  = sel_oh & {3{m_rready}};
        m_arready = |(sel_oh & s_arready);
        m_rvalid  = |(sel_oh & s_rvalid);
        m_rdata   = sel_rdata;
        m_rresp   = sel_rresp;
        if (m_rvalid && m_rready) state_d = StIdle;
      end
      StWr: begin
        s_awvalid = sel_oh & {3{m_awvalid}};
        s_wvalid  = sel_oh & {3{m_wvalid}};
        s_bready  = sel_oh & {3{m_bready}};
        m_awready = |(sel_oh & s_awready);
        m_wready  = |(sel_oh & s_wready);
        m_bvalid  = |(sel_oh & s_bvalid);
        m_bresp   = sel_bresp;
        if (m_bvalid && m_bready) state_d = StIdle;
      end
      StRdErrA: begin
        m_arready = 1'b1;
        state_d   = StRdErrR;
      end
      StRdErrR: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
        if (m_rready) state_d = StIdle;
      end
      StWrErrA: begin
        m_awready = 1'b1;
        m_wready  = 1'b1;
        state_d   = StWrErrB;
      end
      StWrErrB: begin
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
        if (m_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign s0_araddr = m_araddr;
  assign s1_araddr = m_araddr;
  assign s2_araddr = m_araddr;
  assign s0_awaddr = m_awaddr;
  assign s1_awaddr = m_awaddr;
  assign s2_awaddr = m_awaddr;
  assign s0_wdata  = m_wdata;
  assign s1_wdata  = m_wdata;
  assign s2_wdata  = m_wdata;
  assign s0_wstrb  = m_wstrb;
  assign s1_wstrb  = m_wstrb;
  assign s2_wstrb  = m_wstrb;

  assign {s2_arvalid, s1_arvalid, s0_arvalid} = s_arvalid;
  assign {s2_rready, s1_rready, s0_rready}    = s_rready;
  assign {s2_awvalid, s1_awvalid, s0_awvalid} = s_awvalid;
  assign {s2_wvalid, s1_wvalid, s0_wvalid}    = s_wvalid;
  assign {s2_bready, s1_bready, s0_bready}    = s_bready;

endmodule

// File: tb/tb_ysyx_24100006_xbar.sv
// Bench for ysyx_24100006_xbar: directed plus random transactions, expectations from an
// address-map reference model and randomised slave responses.
module tb_ysyx_24100006_xbar;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic        m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
  logic [1:0]  m_rresp, m_bresp;

  logic [31:0] s_araddr[3], s_awaddr[3], s_wdata[3], s_rdata[3];
  logic [3:0]  s_wstrb[3];
  logic [1:0]  s_rresp[3], s_bresp[3];
  logic [2:0]  s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
  logic [2:0]  s_arready, s_awready, s_wready, s_rvalid, s_bvalid;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_24100006_xbar dut (
    .clk(clk), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]),
    .s0_rready(s_rready[0]), .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]),
    .s0_awready(s_awready[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]), .s0_bresp(s_bresp[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]),
    .s1_rready(s_rready[1]), .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]),
    .s1_awready(s_awready[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]), .s1_bresp(s_bresp[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .s2_araddr(s_araddr[2]), .s2_arvalid(s_arvalid[2]), .s2_arready(s_arready[2]),
    .s2_rdata(s_rdata[2]), .s2_rresp(s_rresp[2]), .s2_rvalid(s_rvalid[2]),
    .s2_rready(s_rready[2]), .s2_awaddr(s_awaddr[2]), .s2_awvalid(s_awvalid[2]),
    .s2_awready(s_awready[2]), .s2_wdata(s_wdata[2]), .s2_wstrb(s_wstrb[2]),
    .s2_wvalid(s_wvalid[2]), .s2_wready(s_wready[2]), .s2_bresp(s_bresp[2]),
    .s2_bvalid(s_bvalid[2]), .s2_bready(s_bready[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Address map reference: slot index, or 3 for an unmapped address.
  function automatic int ref_slot(input logic [31:0] a);
    longint x;
    x = {32'h0, a};
    if (x >= 64'h8000_0000 && x < 64'h8000_0000 + 64'h0800_0000) return 0;
    if (x >= 64'ha000_03f8 && x < 64'ha000_03f8 + 64'h8) return 1;
    if (x >= 64'ha000_0048 && x < 64'ha000_0048 + 64'h8) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000 + ($urandom & 32'h07ff_fffc);
      1: return 32'ha000_03f8 + 32'($urandom_range(0, 7));
      2: return 32'ha000_0048 + 32'($urandom_range(0, 7));
      3: return 32'h8800_0000 - 32'($urandom_range(0, 4));
      4: return 32'ha000_0400 - 32'($urandom_range(0, 2));
      5: return 32'ha000_0050 - 32'($urandom_range(0, 2));
      6: return 32'h8000_0000 - 32'($urandom_range(0, 1));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_slaves();
    s_arready = 3'($urandom);
    s_awready = 3'($urandom);
    s_wready  = 3'($urandom);
    s_rvalid  = 3'b000;
    s_bvalid  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s_rdata[i] = $urandom;
      s_rresp[i] = 2'($urandom);
      s_bresp[i] = 2'($urandom);
    end
  endtask

  // Read; with_wr also raises a write request that must wait until the read completes.
  task automatic rd(input logic [31:0] a, input int dly, input bit with_wr,
                    input logic [31:0] wa);
    int slot;
    slot = ref_slot(a);
    rand_slaves();
    @(negedge clk);
    m_araddr = a; m_arvalid = 1'b1; m_rready = 1'b1;
    if (with_wr) begin
      m_awaddr = wa; m_wdata = $urandom; m_wstrb = 4'($urandom);
      m_awvalid = 1'b1; m_wvalid = 1'b1;
    end
    #1;
    chk("rd_idle_arready", 32'(m_arready), 32'd0);
    chk("rd_idle_sarvalid", 32'(s_arvalid), 32'd0);
    @(negedge clk); #1;
    if (slot < 3) begin
      chk("rd_sel_arvalid", 32'(s_arvalid), 32'(1 << slot));
      chk("rd_arready", 32'(m_arready), 32'(s_arready[slot]));
      chk("rd_araddr_bcast", s_araddr[slot], a);
    end else begin
      chk("rderr_arready", 32'(m_arready), 32'd1);
      chk("rderr_sarvalid", 32'(s_arvalid), 32'd0);
    end
    if (with_wr) begin
      chk("rd_blocks_w", 32'({s_awvalid, s_wvalid}), 32'd0);
      chk("rd_blocks_awready", 32'(m_awready), 32'd0);
    end
    @(negedge clk);
    m_arvalid = 1'b0;
    #1;
    if (slot < 3) begin
      for (int i = 0; i < dly; i++) begin
        chk("rd_wait_rvalid", 32'(m_rvalid), 32'd0);
        @(negedge clk); #1;
      end
      s_rvalid[slot] = 1'b1;
      #1;
      chk("rd_rvalid", 32'(m_rvalid), 32'd1);
      chk("rd_rdata", m_rdata, s_rdata[slot]);
      chk("rd_rresp", 32'(m_rresp), 32'(s_rresp[slot]));
      chk("rd_srready", 32'(s_rready), 32'(1 << slot));
    end else begin
      chk("rderr_rvalid", 32'(m_rvalid), 32'd1);
      chk("rderr_rresp", 32'(m_rresp), 32'd3);
      chk("rderr_rdata", m_rdata, 32'd0);
      chk("rderr_srready", 32'(s_rready), 32'd0);
    end
    @(negedge clk);
    s_rvalid = 3'b000;
    #1;
    chk("rd_back_idle", 32'({m_rvalid, m_arready, m_rresp}), 32'd0);
  endtask

  // Write; cont means the request is already raised and the DUT is in IDLE right now.
  task automatic wr(input logic [31:0] a, input int dly, input bit cont);
    int slot;
    logic [31:0] wd;
    logic [3:0]  ws;
    slot = ref_slot(a);
    rand_slaves();
    if (!cont) @(negedge clk);
    wd = $urandom; ws = 4'($urandom);
    m_awaddr = a; m_wdata = wd; m_wstrb = ws;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
    #1;
    chk("wr_idle_ready", 32'({m_awready, m_wready}), 32'd0);
    chk("wr_idle_svalid", 32'({s_awvalid, s_wvalid}), 32'd0);
    @(negedge clk); #1;
    if (slot < 3) begin
      chk("wr_sel_awvalid", 32'(s_awvalid), 32'(1 << slot));
      chk("wr_sel_wvalid", 32'(s_wvalid), 32'(1 << slot));
      chk("wr_awready", 32'(m_awready), 32'(s_awready[slot]));
      chk("wr_wready", 32'(m_wready), 32'(s_wready[slot]));
      chk("wr_wdata_bcast", s_wdata[slot], wd);
      chk("wr_wstrb_bcast", 32'(s_wstrb[slot]), 32'(ws));
      chk("wr_awaddr_bcast", s_awaddr[slot], a);
    end else begin
      chk("wrerr_ready", 32'({m_awready, m_wready}), 32'd3);
      chk("wrerr_svalid", 32'({s_awvalid, s_wvalid}), 32'd0);
    end
    chk("wr_no_ar", 32'(s_arvalid), 32'd0);
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    #1;
    if (slot < 3) begin
      for (int i = 0; i < dly; i++) begin
        chk("wr_wait_bvalid", 32'(m_bvalid), 32'd0);
        @(negedge clk); #1;
      end
      s_bvalid[slot] = 1'b1;
      #1;
      chk("wr_bvalid", 32'(m_bvalid), 32'd1);
      chk("wr_bresp", 32'(m_bresp), 32'(s_bresp[slot]));
      chk("wr_sbready", 32'(s_bready), 32'(1 << slot));
    end else begin
      chk("wrerr_bvalid", 32'(m_bvalid), 32'd1);
      chk("wrerr_bresp", 32'(m_bresp), 32'd3);
      chk("wrerr_sbready", 32'(s_bready), 32'd0);
    end
    @(negedge clk);
    s_bvalid = 3'b000;
    #1;
    chk("wr_back_idle", 32'({m_bvalid, m_awready, m_wready, m_bresp}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; m_rready = 1'b0; m_bready = 1'b0;
    rand_slaves();
    #1;
    chk("reset_master_hs", 32'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 32'd0);
    chk("reset_master_data", {m_rdata[29:0], m_rresp}, 32'd0);
    chk("reset_slave_hs", 32'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    rd(32'h8000_0010, 2, 1'b0, 32'h0);
    wr(32'ha000_03f8, 1, 1'b0);
    rd(32'h9000_0000, 0, 1'b0, 32'h0);
    wr(32'h0000_0000, 0, 1'b0);
    rd(32'ha000_0048, 1, 1'b1, 32'h8000_0000);
    wr(32'h8000_0000, 1, 1'b1);
    rd(32'ha000_03ff, 0, 1'b0, 32'h0);
    rd(32'ha000_0400, 0, 1'b0, 32'h0);
    wr(32'h87ff_fffc, 0, 1'b0);
    wr(32'h8800_0000, 0, 1'b0);

    // Reset while slot 0 holds rvalid: response must vanish without a clock edge.
    @(negedge clk);
    rand_slaves();
    m_araddr = 32'h8000_0010; m_arvalid = 1'b1; m_rready = 1'b0;
    @(negedge clk);
    m_arvalid = 1'b0;
    s_rvalid[0] = 1'b1;
    #1;
    chk("rst_pre_rvalid", 32'(m_rvalid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_rvalid", 32'(m_rvalid), 32'd0);
    chk("rst_async_rdata", m_rdata, 32'd0);
    chk("rst_async_srready", 32'(s_rready), 32'd0);
    s_rvalid = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    rd(32'ha000_004c, 1, 1'b0, 32'h0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) rd(rand_addr(), int'($urandom_range(0, 3)), 1'b0, 32'h0);
      else wr(rand_addr(), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
